// File: rtl/regfile_uart_dump.sv
// Walks the CPU register file through a debug read port and streams every
// 32-bit value out as four 8N1 UART bytes, least-significant byte first.
module regfile_uart_dump #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  dbg_read_reg,
    input  logic [31:0] dbg_read_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [4:0] REG_LAST = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [1:0]    byte_idx;
    logic [1:0]    byte_idx_n;
    logic [1:0]    byte_inc;
    logic [4:0]    reg_idx;
    logic [4:0]    reg_idx_n;
    logic [31:0]   word_buf;
    logic [31:0]   word_buf_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          tx_n;
    logic          busy_n;
    logic          done_n;
    logic          tick;

    assign tick         = (baud == BAUD_LAST);
    assign byte_inc     = byte_idx + 2'd1;
    assign dbg_read_reg = reg_idx;

    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        reg_idx_n  = reg_idx;
        word_buf_n = word_buf;
        shreg_n    = shreg;
        tx_n       = tx;
        busy_n     = busy;
        done_n     = 1'b0;

        // Every baud-timed state is entered on a wrap, so the counter
        // naturally restarts at zero on each state entry.
        if (state == S_START || state == S_DATA || state == S_STOP) begin
            baud_n = tick ? '0 : baud + 1'b1;
        end else begin
            baud_n = '0;
        end

        unique case (state)
            S_IDLE: begin
                tx_n      = 1'b1;
                reg_idx_n = 5'd0;
                if (start) begin
                    state_n = S_FETCH;
                    busy_n  = 1'b1;
                end
            end
            S_FETCH: begin
                word_buf_n = dbg_read_data;
                byte_idx_n = 2'd0;
                shreg_n    = dbg_read_data[7:0];
                tx_n       = 1'b0;
                state_n    = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_n   = S_DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = shreg[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (byte_idx != 2'd3) begin
                        byte_idx_n = byte_inc;
                        shreg_n    = word_buf[{byte_inc, 3'b000} +: 8];
                        tx_n       = 1'b0;
                        state_n    = S_START;
                    end else if (reg_idx != REG_LAST) begin
                        reg_idx_n = reg_idx + 5'd1;
                        state_n   = S_FETCH;
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_n    = 1'b0;
                reg_idx_n = 5'd0;
                state_n   = S_IDLE;
            end
            default: begin
                tx_n      = 1'b1;
                busy_n    = 1'b0;
                reg_idx_n = 5'd0;
                state_n   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud     <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            reg_idx  <= 5'd0;
            word_buf <= 32'd0;
            shreg    <= 8'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            reg_idx  <= reg_idx_n;
            word_buf <= word_buf_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Bench for regfile_uart_dump: two instances (1 and 32 registers) are
// driven with directed and random register contents and decoded as a UART.
module tb_regfile_uart_dump;

    localparam int CPB   = 4;
    localparam int FRAME = 1 + 40 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start32;
    logic [4:0]  reg1;
    logic [4:0]  reg32;
    logic [31:0] data1;
    logic [31:0] data32;
    logic        tx1;
    logic        tx32;
    logic        busy1;
    logic        busy32;
    logic        done1;
    logic        done32;

    logic [31:0] rf1;
    logic [31:0] rf32 [32];
    logic [31:0] snap_val;

    assign data1  = rf1;
    assign data32 = rf32[reg32];

    always #5 clk = ~clk;

    regfile_uart_dump #(.CLKS_PER_BIT(CPB), .NUM_REGS(1)) u_one (
        .clk           (clk),
        .reset         (reset),
        .start         (start1),
        .dbg_read_reg  (reg1),
        .dbg_read_data (data1),
        .tx            (tx1),
        .busy          (busy1),
        .done          (done1)
    );

    regfile_uart_dump #(.CLKS_PER_BIT(CPB), .NUM_REGS(32)) u_full (
        .clk           (clk),
        .reset         (reset),
        .start         (start32),
        .dbg_read_reg  (reg32),
        .dbg_read_data (data32),
        .tx            (tx32),
        .busy          (busy32),
        .done          (done32)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: pulse counts and the cycle numbers of busy/done edges.
    int         dcnt1 = 0, dt1 = 0, rise1 = 0, fall1 = 0;
    int         dcnt32 = 0, dt32 = 0, rise32 = 0, fall32 = 0;
    logic       pb1 = 1'b0, pb32 = 1'b0;
    logic [4:0] preg = 5'd0;
    int         steps = 0, seq_err = 0, hold_err = 0, last_chg = 0;

    always @(negedge clk) begin
        pb1  <= busy1;
        pb32 <= busy32;
        preg <= reg32;
        if (busy1 && !pb1) rise1 <= cyc;
        if (!busy1 && pb1) fall1 <= cyc;
        if (done1) begin
            dcnt1 <= dcnt1 + 1;
            dt1   <= cyc;
        end
        if (busy32 && !pb32) begin
            rise32   <= cyc;
            last_chg <= cyc;
        end
        if (!busy32 && pb32) fall32 <= cyc;
        if (done32) begin
            dcnt32 <= dcnt32 + 1;
            dt32   <= cyc;
        end
        if (reg32 != preg && reg32 != 5'd0) begin
            steps <= steps + 1;
            if (reg32 != preg + 5'd1) seq_err <= seq_err + 1;
            if (cyc - last_chg != FRAME) hold_err <= hold_err + 1;
            last_chg <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? tx32 : tx1;
    endfunction

    // UART receiver: finds the start bit, then samples mid-bit.
    task automatic recv_byte(input int sel, input string tag,
                             output logic [7:0] b);
        int   n;
        logic st;
        logic sp;
        n = 0;
        b = 8'h00;
        while (tx_of(sel) !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, 64'(n < 2000), 64'd1);
        if (n >= 2000) return;
        repeat (2) @(negedge clk);
        st = tx_of(sel);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = tx_of(sel);
        end
        repeat (CPB) @(negedge clk);
        sp = tx_of(sel);
        check({tag, "_frame"}, {62'd0, st, sp}, 64'd1);
    endtask

    task automatic dump_one(input logic [31:0] v, input bit snap);
        logic [7:0] got;
        int         d0;
        d0  = dcnt1;
        rf1 = v;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("one_busy", busy1, 1);
        if (snap) begin
            fork
                begin
                    repeat (2) @(negedge clk);
                    rf1 = snap_val;
                end
            join_none
        end
        for (int b = 0; b < 4; b++) begin
            recv_byte(0, $sformatf("one_b%0d", b), got);
            check($sformatf("one_byte%0d", b), got, v[8*b +: 8]);
        end
        repeat (4) @(negedge clk);
        check("one_done_cnt", dcnt1, d0 + 1);
        check("one_len", dt1 - rise1, FRAME);
        check("one_busy_fall", fall1, dt1 + 1);
    endtask

    task automatic recv_dump32(input bit extra);
        logic [7:0] got;
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                recv_byte(1, $sformatf("x%0d_b%0d", r, b), got);
                check($sformatf("x%0d_byte%0d", r, b), got, rf32[r][8*b +: 8]);
                if (extra && r == 5 && b == 1) begin
                    start32 = 1'b1;
                    @(negedge clk);
                    start32 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int d0;
        int rb;
        reset   = 1'b1;
        start1  = 1'b0;
        start32 = 1'b0;
        rf1     = 32'd0;
        snap_val = 32'd0;
        for (int i = 0; i < 32; i++) rf32[i] = 32'h1000_0000 + i;

        bad = 0;
        repeat (3) @(negedge clk) begin
            if (tx1 !== 1'b1 || tx32 !== 1'b1 || busy1 !== 1'b0 ||
                busy32 !== 1'b0 || done1 !== 1'b0 || done32 !== 1'b0 ||
                reg1 !== 5'd0 || reg32 !== 5'd0) bad++;
        end
        check("reset_outputs", bad, 0);
        reset = 1'b0;
        bad = 0;
        repeat (200) @(negedge clk) begin
            if (tx1 !== 1'b1 || tx32 !== 1'b1 || busy1 !== 1'b0 ||
                busy32 !== 1'b0 || done1 !== 1'b0 || done32 !== 1'b0 ||
                reg32 !== 5'd0) bad++;
        end
        check("idle_quiet", bad, 0);

        dump_one(32'hA5C3_0F81, 1'b0);
        snap_val = 32'h2222_2222;
        dump_one(32'h1111_1111, 1'b1);
        check("snap_rf_changed", rf1, 32'h2222_2222);
        dump_one($urandom, 1'b0);
        check("one_reg_idx", reg1, 0);

        d0 = dcnt32;
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        check("full_busy", busy32, 1);
        recv_dump32(1'b1);
        repeat (4) @(negedge clk);
        check("full_done_cnt", dcnt32, d0 + 1);
        check("full_len", dt32 - rise32, 32 * FRAME);
        check("full_busy_fall", fall32, dt32 + 1);
        check("full_steps", steps, 31);
        check("full_seq_err", seq_err, 0);
        check("full_hold_err", hold_err, 0);
        check("full_idle_reg", reg32, 0);
        check("full_idle_busy", busy32, 0);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 32; i++) rf32[i] = $urandom;
        rf32[0][0] = 1'b0;
        start32 = 1'b1;
        @(negedge clk);
        check("held_busy", busy32, 1);
        @(negedge clk);
        rb = rise32;
        recv_dump32(1'b0);
        repeat (5) @(negedge clk);
        check("held_done_cnt", dcnt32, d0 + 2);
        check("held_len", dt32 - rb, 32 * FRAME);
        check("held_restart", rise32, dt32 + 2);
        check("held_busy2", busy32, 1);
        check("held_start_bit", tx32, 0);
        start32 = 1'b0;

        repeat (6) @(negedge clk);
        check("pre_reset_tx", tx32, 0);
        #1 reset = 1'b1;
        #1;
        check("async_tx", tx32, 1);
        check("async_busy", busy32, 0);
        check("async_done", done32, 0);
        check("async_reg", reg32, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (200) @(negedge clk) begin
            if (tx32 !== 1'b1 || busy32 !== 1'b0 || done32 !== 1'b0) bad++;
        end
        check("post_reset_quiet", bad, 0);
        check("post_reset_done_cnt", dcnt32, d0 + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
